demux_registrado: RTL and testbench

//   Registered 1-to-2 demultiplexer: the inverse of the datapath 2:1 MUX.
//   - Routes one W-bit input word to Saida1 or Saida2, as selected by SinalControle.
//   - Each destination has a one-word holding register with a valid/ready handshake.
//   - Used where a single producer (ALU result, load data) feeds two consumers

---
 rtl/demux_registrado.sv | 107 ++++++++++
 tb/tb_demux_registrado.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/demux_registrado.sv
// Registered 1-to-2 demux with one holding slot per destination.
// Optional per-output transfer counters: define DEMUX_CONTADORES_EN.
module demux_registrado #(
   parameter int LARGURA   = 8,
   parameter int LARG_CONT = 8
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic [LARGURA-1:0] Entrada,
   input  logic               EntradaValida,
   output logic               EntradaPronta,
   input  logic               SinalControle,
   output logic [LARGURA-1:0] Saida1,
   output logic               Saida1Valida,
   input  logic               Saida1Pronta,
   output logic [LARGURA-1:0] Saida2,
   output logic               Saida2Valida,
   input  logic               Saida2Pronta
`ifdef DEMUX_CONTADORES_EN
   ,
   output logic [LARG_CONT-1:0] Contagem1,
   output logic [LARG_CONT-1:0] Contagem2
`endif
);

   typedef enum logic {
      VAZIO = 1'b0,
      CHEIO = 1'b1
   } estado_t;

   estado_t estado1, estado1_prox;
   estado_t estado2, estado2_prox;

   logic aceite;
   logic carga1, carga2;
   logic entrega1, entrega2;

   assign Saida1Valida = (estado1 == CHEIO);
   assign Saida2Valida = (estado2 == CHEIO);

   assign entrega1 = Saida1Valida & Saida1Pronta;
   assign entrega2 = Saida2Valida & Saida2Pronta;

   // A full slot can take a new word only if its consumer drains it now.
   assign EntradaPronta = SinalControle ?
                          (!Saida2Valida | Saida2Pronta) :
                          (!Saida1Valida | Saida1Pronta);

   assign aceite = EntradaValida & EntradaPronta;
   assign carga1 = aceite & !SinalControle;
   assign carga2 = aceite &  SinalControle;

   // Slot state registers.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         estado1 <= VAZIO;
         estado2 <= VAZIO;
      end else begin
         estado1 <= estado1_prox;
         estado2 <= estado2_prox;
      end
   end

   // Next state for both slots; a load while draining keeps the slot full.
   always_comb begin
      estado1_prox = estado1;
      estado2_prox = estado2;
      unique case (estado1)
         VAZIO: if (carga1) estado1_prox = CHEIO;
         CHEIO: if (entrega1 && !carga1) estado1_prox = VAZIO;
         default: estado1_prox = VAZIO;
      endcase
      unique case (estado2)
         VAZIO: if (carga2) estado2_prox = CHEIO;
         CHEIO: if (entrega2 && !carga2) estado2_prox = VAZIO;
         default: estado2_prox = VAZIO;
      endcase
   end

   // Holding registers load only on an accepted word for their slot.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         Saida1 <= '0;
         Saida2 <= '0;
      end else begin
         if (carga1) Saida1 <= Entrada;
         if (carga2) Saida2 <= Entrada;
      end
   end

`ifdef DEMUX_CONTADORES_EN
   // Delivered-word counters, wrapping silently.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         Contagem1 <= '0;
         Contagem2 <= '0;
      end else begin
         if (entrega1) Contagem1 <= Contagem1 + 1'b1;
         if (entrega2) Contagem2 <= Contagem2 + 1'b1;
      end
   end
`else
   if (LARG_CONT < 1) begin : g_larg_cont_invalida
   end
`endif

endmodule

// File: tb/tb_demux_registrado.sv
// Randomized and directed bench for demux_registrado.
// Reference model: one bounded queue per destination.
module tb_demux_registrado;

   localparam int W  = 8;
   localparam int WC = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] ent;
   logic         ev;
   logic         epr;
   logic         sc;
   logic [W-1:0] s1, s2;
   logic         v1, v2;
   logic         p1, p2;
`ifdef DEMUX_CONTADORES_EN
   logic [WC-1:0] c1, c2;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   logic [W-1:0] q1[$];
   logic [W-1:0] q2[$];
   logic [W-1:0] last1, last2;
   int           cnt1, cnt2;
   logic         pr_seen;

   always #5 clk = ~clk;

   demux_registrado #(
      .LARGURA  (W),
      .LARG_CONT(WC)
   ) dut (
      .Clock        (clk),
      .Reset        (rst),
      .Entrada      (ent),
      .EntradaValida(ev),
      .EntradaPronta(epr),
      .SinalControle(sc),
      .Saida1       (s1),
      .Saida1Valida (v1),
      .Saida1Pronta (p1),
      .Saida2       (s2),
      .Saida2Valida (v2),
      .Saida2Pronta (p2)
`ifdef DEMUX_CONTADORES_EN
      ,
      .Contagem1    (c1),
      .Contagem2    (c2)
`endif
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive, check handshake, advance model, check outputs.
   task automatic cycle(input logic r, input logic v, input logic [W-1:0] d,
                        input logic s, input logic a1, input logic a2);
      logic exp_pr;
      logic acc;
      @(negedge clk);
      rst = r; ev = v; ent = d; sc = s; p1 = a1; p2 = a2;
      #1;
      exp_pr = s ? (q2.size() == 0 || a2) : (q1.size() == 0 || a1);
      pr_seen = epr;
      chk("pronta", epr, exp_pr);
      acc = v & exp_pr;
      @(posedge clk);
      if (r) begin
         q1.delete(); q2.delete();
         last1 = '0; last2 = '0;
         cnt1 = 0; cnt2 = 0;
      end else begin
         if (q1.size() != 0 && a1) begin
            void'(q1.pop_front());
            cnt1 = (cnt1 + 1) % (1 << WC);
         end
         if (q2.size() != 0 && a2) begin
            void'(q2.pop_front());
            cnt2 = (cnt2 + 1) % (1 << WC);
         end
         if (acc && !s) begin q1.push_back(d); last1 = d; end
         if (acc &&  s) begin q2.push_back(d); last2 = d; end
      end
      #1;
      chk("valida1", v1, q1.size() != 0);
      chk("valida2", v2, q2.size() != 0);
      chk("saida1", s1, last1);
      chk("saida2", s2, last2);
      chk("slot_cap", (q1.size() <= 1) && (q2.size() <= 1), 1);
`ifdef DEMUX_CONTADORES_EN
      chk("cont1", c1, cnt1);
      chk("cont2", c2, cnt2);
`endif
   endtask

   initial begin
      rst = 1'b1; ev = 1'b0; ent = '0; sc = 1'b0; p1 = 1'b0; p2 = 1'b0;
      last1 = '0; last2 = '0; cnt1 = 0; cnt2 = 0;

      // 1: reset for two cycles
      cycle(1, 0, 8'h00, 0, 0, 0);
      cycle(1, 0, 8'h00, 0, 0, 0);
      cycle(0, 0, 8'h00, 0, 0, 0);
      chk("t1_v1", v1, 0);
      chk("t1_v2", v2, 0);
      chk("t1_s1", s1, 0);
      chk("t1_s2", s2, 0);
      chk("t1_pr", pr_seen, 1);

      // 2: word to Saida1, consumer stalled
      cycle(0, 1, 8'hAA, 0, 0, 0);
      chk("t2_s1", s1, 8'hAA);
      chk("t2_v1", v1, 1);
      chk("t2_v2", v2, 0);

      // 3: blocked on slot 1, rerouted to slot 2
      cycle(0, 1, 8'h55, 0, 0, 0);
      chk("t3_block", pr_seen, 0);
      chk("t3_hold", s1, 8'hAA);
      cycle(0, 1, 8'h55, 1, 0, 0);
      chk("t3_pr", pr_seen, 1);
      chk("t3_s2", s2, 8'h55);
      chk("t3_s1", s1, 8'hAA);

      // 4: alternating stream at full rate
      for (int i = 1; i <= 16; i++) begin
         cycle(0, 1, W'(i), i[0] ? 1'b0 : 1'b1, 1, 1);
         chk("t4_nostall", pr_seen, 1);
         if (i[0]) chk("t4_s1", s1, i);
         else      chk("t4_s2", s2, i);
      end
      cycle(0, 0, 8'h00, 0, 1, 1);

      // 5: back-to-back replace on slot 2
      cycle(0, 1, 8'h7F, 1, 0, 0);
      chk("t5_s2a", s2, 8'h7F);
      cycle(0, 1, 8'hFE, 1, 0, 1);
      chk("t5_pr", pr_seen, 1);
      chk("t5_s2b", s2, 8'hFE);
      chk("t5_v2", v2, 1);

      // 6: counter wrap after 17 deliveries, then reset while full
      cycle(1, 0, 8'h00, 0, 0, 0);
      for (int i = 0; i < 17; i++) cycle(0, 1, W'(8'h20 + i), 0, 1, 0);
      cycle(0, 0, 8'h00, 0, 1, 0);
`ifdef DEMUX_CONTADORES_EN
      chk("t6_wrap", c1, 1);
`endif
      cycle(0, 1, 8'h99, 0, 0, 0);
      chk("t6_full", v1, 1);
      cycle(1, 0, 8'h00, 0, 0, 0);
      chk("t6_v1", v1, 0);
`ifdef DEMUX_CONTADORES_EN
      chk("t6_cnt", c1, 0);
`endif

      // random traffic with occasional reset
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(63) == 0), 1'($urandom), 8'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
